// File: rtl/half_sub_46_pkg.sv
// half_sub_46_pkg
//   Shared defaults for the registered multi-lane half subtractor.
//   DEFAULT_WIDTH : lane count when no override is given
//   DEFAULT_CNT_W : borrow-event counter width when no override is given
package half_sub_46_pkg;

  localparam int DEFAULT_WIDTH = 1;
  localparam int DEFAULT_CNT_W = 16;

endpackage

// File: rtl/half_sub_46_if.sv
// half_sub_46_if
//   Bundles the data, strobe and status signals of half_sub_46.
//   master : drives a, b, in_valid, cnt_clr; observes results and status
//   slave  : the subtractor itself
interface half_sub_46_if
  import half_sub_46_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = DEFAULT_CNT_W
);

  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             in_valid;
  logic             cnt_clr;
  logic [WIDTH-1:0] diff_c;
  logic [WIDTH-1:0] borr_c;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] borr;
  logic             out_valid;
  logic [CNT_W-1:0] borr_cnt;

  modport master (
    output a, b, in_valid, cnt_clr,
    input  diff_c, borr_c, diff, borr, out_valid, borr_cnt
  );

  modport slave (
    input  a, b, in_valid, cnt_clr,
    output diff_c, borr_c, diff, borr, out_valid, borr_cnt
  );

endinterface

// File: rtl/half_sub_46_lane.sv
// half_sub_46_lane
//   Single-bit combinational half subtractor cell.
//   a, b : minuend / subtrahend bit
//   diff : a ^ b
//   borr : ~a & b
module half_sub_46_lane (
  input  logic a,
  input  logic b,
  output logic diff,
  output logic borr
);

  assign diff = a ^ b;
  assign borr = ~a & b;

endmodule

// File: rtl/half_sub_46.sv
// half_sub_46
//   Registered multi-lane half subtractor with a saturating borrow counter.
//   clk, rst_n : rising-edge clock, asynchronous active-low reset
//   bus.a/b/in_valid      : per-lane operands and their strobe
//   bus.cnt_clr           : synchronous clear of borr_cnt (wins over increment)
//   bus.diff_c/borr_c     : combinational results, live even during reset
//   bus.diff/borr         : results registered one cycle behind in_valid
//   bus.out_valid         : diff/borr were loaded on the previous edge
//   bus.borr_cnt          : saturating count of lanes that produced a borrow
module half_sub_46
  import half_sub_46_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic          clk,
  input  logic          rst_n,
  half_sub_46_if.slave  bus
);

  localparam int               POP_W   = $clog2(WIDTH + 1);
  localparam int               SUM_W   = ((CNT_W > POP_W) ? CNT_W : POP_W) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [WIDTH-1:0] diff_w;
  logic [WIDTH-1:0] borr_w;

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    half_sub_46_lane u_lane (
      .a    (bus.a[i]),
      .b    (bus.b[i]),
      .diff (diff_w[i]),
      .borr (borr_w[i])
    );
  end

  assign bus.diff_c = diff_w;
  assign bus.borr_c = borr_w;

  logic [WIDTH-1:0] diff_q, diff_d;
  logic [WIDTH-1:0] borr_q, borr_d;
  logic             out_valid_q, out_valid_d;
  logic [CNT_W-1:0] borr_cnt_q, borr_cnt_d;
  logic [POP_W-1:0] borr_pop;
  logic [SUM_W-1:0] cnt_sum;

  always_comb begin
    borr_pop = '0;
    for (int i = 0; i < WIDTH; i++) begin
      borr_pop = borr_pop + POP_W'(borr_w[i]);
    end
  end

  // Sum is computed one bit wider than either operand so overflow is visible
  // and the counter can clamp instead of wrapping.
  assign cnt_sum = SUM_W'(borr_cnt_q) + SUM_W'(borr_pop);

  always_comb begin
    diff_d      = diff_q;
    borr_d      = borr_q;
    out_valid_d = bus.in_valid;
    borr_cnt_d  = borr_cnt_q;

    if (bus.in_valid) begin
      diff_d = diff_w;
      borr_d = borr_w;
    end

    if (bus.cnt_clr) begin
      borr_cnt_d = '0;
    end else if (bus.in_valid) begin
      if (cnt_sum > SUM_W'(CNT_MAX)) begin
        borr_cnt_d = CNT_MAX;
      end else begin
        borr_cnt_d = cnt_sum[CNT_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      diff_q      <= '0;
      borr_q      <= '0;
      out_valid_q <= 1'b0;
      borr_cnt_q  <= '0;
    end else begin
      diff_q      <= diff_d;
      borr_q      <= borr_d;
      out_valid_q <= out_valid_d;
      borr_cnt_q  <= borr_cnt_d;
    end
  end

  assign bus.diff      = diff_q;
  assign bus.borr      = borr_q;
  assign bus.out_valid = out_valid_q;
  assign bus.borr_cnt  = borr_cnt_q;

endmodule

// File: tb/tb_half_sub_46.sv
// tb_half_sub_46
//   Directed bench for half_sub_46 with WIDTH=4, CNT_W=2 so that lane
//   independence, popcount and counter saturation are all reachable.
module tb_half_sub_46;

  localparam int W       = 4;
  localparam int CW      = 2;
  localparam int CNT_TOP = 3;

  typedef struct packed {
    logic [W-1:0] d;
    logic [W-1:0] b;
  } res_t;

  logic clk;
  logic rst_n;

  half_sub_46_if #(.WIDTH(W), .CNT_W(CW)) bus ();

  half_sub_46 #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int           checks = 0;
  int           errors = 0;
  res_t         exp_q[$];
  logic [W-1:0] held_diff = '0;
  logic [W-1:0] held_borr = '0;
  logic         exp_valid = 1'b0;
  int           exp_cnt   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Registered outputs seen now reflect the previous edge.
  task automatic check_regs(input string tag);
    res_t e;
    chk({tag, " out_valid"}, 32'(bus.out_valid), 32'(exp_valid));
    if (exp_valid) begin
      if (exp_q.size() == 0) begin
        chk({tag, " scoreboard_empty"}, 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        held_diff = e.d;
        held_borr = e.b;
      end
    end
    chk({tag, " diff"}, 32'(bus.diff), 32'(held_diff));
    chk({tag, " borr"}, 32'(bus.borr), 32'(held_borr));
    chk({tag, " borr_cnt"}, 32'(bus.borr_cnt), 32'(exp_cnt));
  endtask

  task automatic drive(input string tag, input logic [W-1:0] ai, input logic [W-1:0] bi,
                       input logic vi, input logic ci);
    int   pop;
    res_t r;
    @(negedge clk);
    check_regs(tag);
    bus.a        = ai;
    bus.b        = bi;
    bus.in_valid = vi;
    bus.cnt_clr  = ci;
    #1;
    if (!$isunknown({ai, bi})) begin
      chk({tag, " diff_c"}, 32'(bus.diff_c), 32'(ai ^ bi));
      chk({tag, " borr_c"}, 32'(bus.borr_c), 32'(~ai & bi));
    end
    pop = 0;
    for (int i = 0; i < W; i++) if (ai[i] == 1'b0 && bi[i] == 1'b1) pop++;
    if (ci) exp_cnt = 0;
    else if (vi) exp_cnt = (exp_cnt + pop > CNT_TOP) ? CNT_TOP : exp_cnt + pop;
    if (vi) begin
      r.d = ai ^ bi;
      r.b = ~ai & bi;
      exp_q.push_back(r);
    end
    exp_valid = vi;
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    logic         rv, rc;

    rst_n        = 1'b0;
    bus.a        = '0;
    bus.b        = '0;
    bus.in_valid = 1'b0;
    bus.cnt_clr  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Exhaustive truth table on lane 0
    drive("ex00", 4'b0000, 4'b0000, 1'b1, 1'b0);
    drive("ex01", 4'b0000, 4'b0001, 1'b1, 1'b0);
    drive("ex10", 4'b0001, 4'b0000, 1'b1, 1'b0);
    drive("ex11", 4'b0001, 4'b0001, 1'b1, 1'b0);
    drive("clr0", 4'b0000, 4'b0000, 1'b0, 1'b1);

    // Asynchronous reset between edges
    drive("prerst", 4'b0000, 4'b0001, 1'b1, 1'b0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst diff", 32'(bus.diff), 32'd0);
    chk("rst borr", 32'(bus.borr), 32'd0);
    chk("rst borr_cnt", 32'(bus.borr_cnt), 32'd0);
    exp_q.delete();
    held_diff = '0;
    held_borr = '0;
    exp_valid = 1'b0;
    exp_cnt   = 0;
    bus.in_valid = 1'b0;
    bus.a = 4'b0011;
    bus.b = 4'b0101;
    #1;
    chk("rst diff_c", 32'(bus.diff_c), 32'(4'b0110));
    chk("rst borr_c", 32'(bus.borr_c), 32'(4'b0100));
    @(negedge clk);
    rst_n = 1'b1;
    drive("postrst_idle", 4'b0000, 4'b0000, 1'b0, 1'b0);
    drive("postrst_v", 4'b0000, 4'b0001, 1'b1, 1'b0);

    // Multi-lane result then hold
    drive("clr1", 4'b0000, 4'b0000, 1'b0, 1'b1);
    drive("ml", 4'b0101, 4'b0011, 1'b1, 1'b0);
    drive("hold1", 4'b1111, 4'b0000, 1'b0, 1'b0);
    drive("hold2", 4'b0000, 4'b1111, 1'b0, 1'b0);
    drive("hold3", 4'b1010, 4'b0101, 1'b0, 1'b0);

    // Saturation, one borrow per sample
    drive("clr2", 4'b0000, 4'b0000, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) drive("sat", 4'b0000, 4'b0001, 1'b1, 1'b0);

    // Multi-borrow popcount and saturation
    drive("clr3", 4'b0000, 4'b0000, 1'b0, 1'b1);
    drive("pop3", 4'b0000, 4'b1110, 1'b1, 1'b0);
    drive("clr4", 4'b0000, 4'b0000, 1'b0, 1'b1);
    drive("pop1", 4'b0000, 4'b0100, 1'b1, 1'b0);
    drive("pop2sat", 4'b1000, 4'b0110, 1'b1, 1'b0);

    // Clear priority over a borrowing sample
    drive("clr5", 4'b0000, 4'b0000, 1'b0, 1'b1);
    drive("cp1", 4'b0000, 4'b0001, 1'b1, 1'b0);
    drive("cp2", 4'b0000, 4'b0001, 1'b1, 1'b0);
    drive("cp_clr", 4'b0010, 4'b0011, 1'b1, 1'b1);
    drive("cp3", 4'b0000, 4'b0001, 1'b1, 1'b0);

    // Unknown operands while idle
    drive("xidle", 'x, 'x, 1'b0, 1'b0);
    drive("xidle2", 4'b0000, 4'b0000, 1'b0, 1'b0);

    // Random mix
    for (int i = 0; i < 24; i++) begin
      ra = 4'($urandom);
      rb = 4'($urandom);
      rv = 1'($urandom_range(0, 1));
      rc = ($urandom_range(0, 7) == 0);
      drive("rnd", ra, rb, rv, rc);
    end
    drive("final", 4'b0000, 4'b0000, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
